// File: rtl/fpmul_share_arbiter_if.sv
// Bundle for fpmul_share_arbiter: requester side (req/gnt/res_*) plus the
// multiplier-core side (mul_start/mul_done). Arbiter uses 'slave'; environment uses 'master'.
interface fpmul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  // Handshakes: a requester holds req[i] (operands valid) until it sees the
  // one-cycle gnt[i]; its product arrives later as a one-cycle res_valid[i]
  // with res_out/res_err. Toward the core, mul_start is a one-cycle launch
  // with mul_a/mul_b valid, and mul_done is a one-cycle strobe with mul_result.
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa_in;
  logic [NREQ*W-1:0] opb_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      res_out;
  logic [NREQ-1:0]   res_valid;
  logic              res_err;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [W-1:0]      mul_result;

  modport slave (
    input  req, opa_in, opb_in, mul_done, mul_result,
    output gnt, res_out, res_valid, res_err, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, opa_in, opb_in, mul_done, mul_result,
    input  gnt, res_out, res_valid, res_err, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/fpmul_share_arbiter.sv
// Round-robin sharing of one floating-point multiplier core among NREQ requesters.
// Define FPMUL_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts a job after TMO cycles.
module fpmul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int TMO  = 64
) (
  input  logic                 CLK,
  input  logic                 Reset,
  fpmul_share_arbiter_if.slave bus,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8 || TMO < 2) begin : g_bad_params
    $error("fpmul_share_arbiter: NREQ must be 2..8 and TMO at least 2");
  end

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic          found;

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO);
  logic [CW-1:0] wdog;
`endif

  assign state_dbg = state;

  // Search starts just above the last winner, so a held request waits at most NREQ-1 jobs.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(last) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      last          <= IW'(NREQ - 1);
      sel           <= '0;
      bus.gnt       <= '0;
      bus.res_valid <= '0;
      bus.res_err   <= 1'b0;
      bus.res_out   <= '0;
      bus.busy      <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      wdog          <= '0;
`endif
    end else begin
      bus.gnt       <= '0;
      bus.res_valid <= '0;
      bus.mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= pick;
            last      <= pick;
            bus.gnt   <= NREQ'(1) << pick;
            bus.mul_a <= bus.opa_in[int'(pick)*W +: W];
            bus.mul_b <= bus.opb_in[int'(pick)*W +: W];
            bus.busy  <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.mul_start <= 1'b1;
`ifdef FPMUL_ARB_TIMEOUT_EN
          wdog          <= '0;
`endif
          state         <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            bus.res_out   <= bus.mul_result;
            bus.res_valid <= NREQ'(1) << sel;
            bus.res_err   <= 1'b0;
            state         <= DELIVER;
          end
`ifdef FPMUL_ARB_TIMEOUT_EN
          else if (wdog == CW'(TMO - 1)) begin
            bus.res_out   <= '0;
            bus.res_valid <= NREQ'(1) << sel;
            bus.res_err   <= 1'b1;
            state         <= DELIVER;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        DELIVER: begin
          bus.res_err <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpmul_share_arbiter.md
Name: fpmul_share_arbiter

Overview:
Shares one floating-point multiplier core between NREQ independent requesters. Arbitration is round-robin. The block latches the winner's operands, launches the core, waits for the core's completion strobe, and returns the product to the winner with a one-cycle valid pulse. It sits between the requesting engines and the single multiplier core, and supersedes direct Start/Done wiring to that core.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width (IEEE-754 single)
TMO, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  reset, asynchronous, active-high
req  in  NREQ  request per requester; held high until gnt bit seen
opa_in  in  NREQ*W  operand A per requester; slice i = [i*W +: W]
opb_in  in  NREQ*W  operand B per requester, same packing
gnt  out  NREQ  one-hot grant, one-cycle pulse
res_out  out  W  product, valid while any res_valid bit is high
res_valid  out  NREQ  one-hot result strobe, one-cycle pulse
res_err  out  1  high with res_valid when the result was aborted
busy  out  1  high in every state except IDLE
mul_start  out  1  one-cycle launch pulse to the core
mul_a  out  W  registered operand A to the core
mul_b  out  W  registered operand B to the core
mul_done  in  1  core completion strobe
mul_result  in  W  core product, sampled when mul_done is high

Behaviour:
- Reset asynchronous: state=IDLE, last=NREQ-1, all outputs 0 (gnt, res_valid, res_err, busy, mul_start, mul_a, mul_b, res_out).
- Reset mid-operation: the in-flight job is dropped and no res_valid is issued; the core is not notified.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - If req is non-zero, choose the first set bit searching from (last+1) mod NREQ upward with wrap-around.
  - Set sel=i and last=i, gnt[i]=1 for one cycle, mul_a/mul_b <= slice i, then go to LAUNCH.
  - If req=0, stay in IDLE.
- LAUNCH: mul_start=1 for exactly one cycle, then go to WAIT. mul_done sampled in LAUNCH is ignored (core latency is at least 1).
- WAIT:
  - On mul_done=1, capture res_out <= mul_result and go to DELIVER.
  - Otherwise stay in WAIT. req changes are ignored; new requests queue implicitly by remaining asserted.
- DELIVER: res_valid[sel]=1 and res_err as set, one cycle, then go to IDLE. Arbitration resumes in IDLE the following cycle.
- mul_done outside WAIT is ignored with no state change.
- Requester protocol:
  - Drop req the cycle after seeing gnt.
  - If req is still high in IDLE after DELIVER, it counts as a new request and is ranked normally.
  - Operands need to be stable only on the cycle gnt is issued.
- Timing, with core latency L cycles from mul_start to mul_done:
  - gnt at T+1 after req sampled at T.
  - mul_start at T+2.
  - res_valid at T+2+L+1.
  - Minimum request-to-result = L+3 cycles; throughput = one job per L+4 cycles.
- Fairness: a requester that held req continuously waits at most NREQ-1 jobs.
- Without the optional feature, res_err is constant 0.

Optional Feature:
Macro: FPMUL_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the count reaches TMO-1 without mul_done, go to DELIVER with res_out=0 and res_err=1.
  - A late mul_done after the timeout is ignored by the ignore-outside-WAIT rule.
- Undefined: the counter logic is absent, WAIT waits indefinitely, and res_err is tied to 0.

Test Plan:
- Single job: req=0001, opa0=0x3FC00000, opb0=0x40000000, core L=3, mul_result=0x40400000 -> gnt=0001 at T+1; mul_start at T+2 with mul_a=0x3FC00000, mul_b=0x40000000; res_valid=0001 at T+6 with res_out=0x40400000 and res_err=0.
- All four requesters: req=1111 held, each dropped after its grant -> grants in order 0001, 0010, 0100, 1000; res_valid order matches; busy is high throughout except the single IDLE cycles.
- Fairness: req0 held continuously, req2 raised during job 0 -> grant sequence 0, 2, 0, 2, with no two consecutive grants to requester 0 while req2 is pending.
- Spurious done: pulse mul_done in IDLE and in LAUNCH -> no state change, no res_valid, mul_start count unchanged.
- Reset mid-WAIT: assert Reset two cycles after mul_start -> all outputs 0 immediately; a later mul_done produces no res_valid; the next req=0100 gets gnt=0100 (pointer was reset).
- Timeout (with FPMUL_ARB_TIMEOUT_EN, TMO=8): core never asserts mul_done -> res_valid at the selected bit 8 cycles after WAIT entry, with res_err=1 and res_out=0; a late mul_done is ignored.
